// File: rtl/des_keyex.sv
// Iterative DES key schedule: one 48-bit subkey per clock, K1..K16 packed MSB-first.
// Optional byte parity check on accepted keys when DES_KEY_PARITY_EN is defined.
module des_keyex (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [63:0]  i_key,
    input  logic         i_key_en,
    output logic [767:0] o_keyex,
    output logic         o_key_ok,
    output logic         o_key_err
);

    function automatic logic [55:0] pc1(input logic [63:0] k);
        return {k[7],  k[15], k[23], k[31], k[39], k[47], k[55],
                k[63], k[6],  k[14], k[22], k[30], k[38], k[46],
                k[54], k[62], k[5],  k[13], k[21], k[29], k[37],
                k[45], k[53], k[61], k[4],  k[12], k[20], k[28],
                k[1],  k[9],  k[17], k[25], k[33], k[41], k[49],
                k[57], k[2],  k[10], k[18], k[26], k[34], k[42],
                k[50], k[58], k[3],  k[11], k[19], k[27], k[35],
                k[43], k[51], k[59], k[36], k[44], k[52], k[60]};
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] s);
        return {s[42], s[39], s[45], s[32], s[55], s[51],
                s[53], s[28], s[41], s[50], s[35], s[46],
                s[33], s[37], s[44], s[52], s[30], s[48],
                s[40], s[49], s[29], s[36], s[43], s[54],
                s[15], s[4],  s[25], s[19], s[9],  s[1],
                s[26], s[16], s[5],  s[11], s[23], s[8],
                s[12], s[7],  s[17], s[0],  s[22], s[3],
                s[10], s[14], s[6],  s[20], s[27], s[24]};
    endfunction

    logic [27:0]  r_c, r_d;
    logic [27:0]  w_c_nxt, w_d_nxt;
    logic [27:0]  w_c_rot, w_d_rot;
    logic [4:0]   r_cnt, w_cnt_nxt;
    logic [767:0] r_keyex, w_keyex_nxt;
    logic         r_ok, w_ok_nxt;
    logic         w_one;
    logic         w_par_ok;
    logic [55:0]  w_pc1;
    logic [47:0]  w_sub;
    logic [15:0]  w_sel;
    logic [767:0] w_mask;

    assign w_pc1 = pc1(i_key);

    assign w_one = (r_cnt == 5'd1) || (r_cnt == 5'd2) ||
                   (r_cnt == 5'd9) || (r_cnt == 5'd16);

    assign w_c_rot = w_one ? {r_c[26:0], r_c[27]} : {r_c[25:0], r_c[27:26]};
    assign w_d_rot = w_one ? {r_d[26:0], r_d[27]} : {r_d[25:0], r_d[27:26]};
    assign w_sub   = pc2({w_c_rot, w_d_rot});

    // Slot k occupies [767-48(k-1) -: 48]; mask selects the slot for r_cnt
    for (genvar g = 0; g < 16; g++) begin : g_slot
        assign w_sel[g] = (r_cnt == 5'(g + 1));
        assign w_mask[(15 - g) * 48 +: 48] = {48{w_sel[g]}};
    end

`ifdef DES_KEY_PARITY_EN
    logic [7:0] w_byte_odd;
    logic       r_err, w_err_nxt;

    for (genvar b = 0; b < 8; b++) begin : g_par
        assign w_byte_odd[b] = ^i_key[8 * b +: 8];
    end

    assign w_par_ok  = &w_byte_odd;
    assign o_key_err = r_err;
`else
    assign w_par_ok  = 1'b1;
    assign o_key_err = 1'b0;
`endif

    always_comb begin
        w_c_nxt     = r_c;
        w_d_nxt     = r_d;
        w_cnt_nxt   = r_cnt;
        w_keyex_nxt = r_keyex;
        w_ok_nxt    = r_ok;
`ifdef DES_KEY_PARITY_EN
        w_err_nxt   = r_err;
`endif
        if (i_key_en) begin
            w_ok_nxt  = 1'b0;
`ifdef DES_KEY_PARITY_EN
            w_err_nxt = 1'b0;
`endif
            if (w_par_ok) begin
                {w_c_nxt, w_d_nxt} = w_pc1;
                w_cnt_nxt          = 5'd1;
            end else begin
`ifdef DES_KEY_PARITY_EN
                w_err_nxt = 1'b1;
`endif
                w_cnt_nxt = 5'd0;
            end
        end else if (r_cnt != 5'd0) begin
            w_c_nxt     = w_c_rot;
            w_d_nxt     = w_d_rot;
            w_keyex_nxt = (r_keyex & ~w_mask) | ({16{w_sub}} & w_mask);
            if (r_cnt == 5'd16) begin
                w_cnt_nxt = 5'd0;
                w_ok_nxt  = 1'b1;
            end else begin
                w_cnt_nxt = r_cnt + 5'd1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_c     <= '0;
            r_d     <= '0;
            r_cnt   <= '0;
            r_keyex <= '0;
            r_ok    <= 1'b0;
`ifdef DES_KEY_PARITY_EN
            r_err   <= 1'b0;
`endif
        end else begin
            r_c     <= w_c_nxt;
            r_d     <= w_d_nxt;
            r_cnt   <= w_cnt_nxt;
            r_keyex <= w_keyex_nxt;
            r_ok    <= w_ok_nxt;
`ifdef DES_KEY_PARITY_EN
            r_err   <= w_err_nxt;
`endif
        end
    end

    assign o_keyex  = r_keyex;
    assign o_key_ok = r_ok;

endmodule

// File: tb/tb_des_keyex.sv
// Directed self-checking bench for des_keyex.
// Parity-error step follows DES_KEY_PARITY_EN.
module tb_des_keyex;

    logic         clk;
    logic         rst;
    logic [63:0]  key;
    logic         key_en;
    logic [767:0] keyex;
    logic         key_ok;
    logic         key_err;

    int checks = 0;
    int errors = 0;
    int lat;
    int seen;

    localparam logic [63:0] KEY_A  = 64'h133457799BBCDFF1;
    localparam logic [63:0] KEY_W  = 64'h0101010101010101;
    localparam logic [55:0] PC1_A  = 56'hF0CCAAF556678F;
    localparam logic [47:0] K1_A   = 48'h1B02EFFC7072;
    localparam logic [47:0] K2_A   = 48'h79AED9DBC9E5;
    localparam logic [47:0] K16_A  = 48'hCB3D8B0E17F5;

    des_keyex dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_key     (key),
        .i_key_en  (key_en),
        .o_keyex   (keyex),
        .o_key_ok  (key_ok),
        .o_key_err (key_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] fold(input logic [767:0] v);
        logic [63:0] w;
        w = '0;
        for (int i = 0; i < 12; i++) w = w | 64'(v >> (64 * i));
        return w;
    endfunction

    task automatic accept(input logic [63:0] k);
        key    = k;
        key_en = 1'b1;
        tick();
        key_en = 1'b0;
    endtask

    task automatic wait_ok(output int n);
        n = 0;
        while (key_ok !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
    endtask

    initial begin
        rst    = 1'b1;
        key    = '0;
        key_en = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_ok", 64'(key_ok), 64'd0);
        chk("rst_err", 64'(key_err), 64'd0);
        chk("rst_keyex", fold(keyex), 64'd0);
        chk("rst_cd", 64'({dut.r_c, dut.r_d}), 64'd0);
        chk("rst_cnt", 64'(dut.r_cnt), 64'd0);

        accept(KEY_A);
        chk("acc_cd", 64'({dut.r_c, dut.r_d}), 64'(PC1_A));
        chk("acc_ok", 64'(key_ok), 64'd0);
        wait_ok(lat);
        chk("a_latency", 64'(lat), 64'd16);
        chk("a_k1", 64'(keyex[767:720]), 64'(K1_A));
        chk("a_k2", 64'(keyex[719:672]), 64'(K2_A));
        chk("a_k16", 64'(keyex[47:0]), 64'(K16_A));
        chk("a_cd_wrap", 64'({dut.r_c, dut.r_d}), 64'(PC1_A));
        chk("a_err", 64'(key_err), 64'd0);

        accept(KEY_W);
        chk("w_ok_drop", 64'(key_ok), 64'd0);
        wait_ok(lat);
        chk("w_latency", 64'(lat), 64'd16);
        chk("w_keyex", fold(keyex), 64'd0);

        accept(KEY_A);
        repeat (7) tick();
        chk("r_cnt8", 64'(dut.r_cnt), 64'd8);
        accept(KEY_W);
        chk("r_ok_low", 64'(key_ok), 64'd0);
        wait_ok(lat);
        chk("r_latency", 64'(lat), 64'd16);
        chk("r_keyex", fold(keyex), 64'd0);

        accept(KEY_A);
        repeat (15) tick();
        chk("b_cnt16", 64'(dut.r_cnt), 64'd16);
        accept(KEY_W);
        chk("b_ok_low", 64'(key_ok), 64'd0);
        chk("b_cnt1", 64'(dut.r_cnt), 64'd1);
        wait_ok(lat);
        chk("b_latency", 64'(lat), 64'd16);
        chk("b_keyex", fold(keyex), 64'd0);

        accept(KEY_A);
        repeat (9) tick();
        chk("m_cnt10", 64'(dut.r_cnt), 64'd10);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("m_ok", 64'(key_ok), 64'd0);
        chk("m_err", 64'(key_err), 64'd0);
        chk("m_keyex", fold(keyex), 64'd0);
        chk("m_cnt", 64'(dut.r_cnt), 64'd0);
        seen = 0;
        repeat (40) begin
            tick();
            if (key_ok === 1'b1) seen++;
        end
        chk("m_ok_idle", 64'(seen), 64'd0);

        accept(KEY_A);
        wait_ok(lat);
        chk("p_pre_lat", 64'(lat), 64'd16);
        accept(64'h0);
`ifdef DES_KEY_PARITY_EN
        chk("p_err", 64'(key_err), 64'd1);
        chk("p_ok", 64'(key_ok), 64'd0);
        repeat (20) tick();
        chk("p_ok_hold", 64'(key_ok), 64'd0);
        chk("p_k1_kept", 64'(keyex[767:720]), 64'(K1_A));
        chk("p_k16_kept", 64'(keyex[47:0]), 64'(K16_A));
        accept(KEY_A);
        chk("p_err_clr", 64'(key_err), 64'd0);
        wait_ok(lat);
        chk("p_post_lat", 64'(lat), 64'd16);
        chk("p_post_k1", 64'(keyex[767:720]), 64'(K1_A));
`else
        chk("z_ok_drop", 64'(key_ok), 64'd0);
        wait_ok(lat);
        chk("z_latency", 64'(lat), 64'd16);
        chk("z_keyex", fold(keyex), 64'd0);
        chk("z_err", 64'(key_err), 64'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
